// File: rtl/bram_arb_pkg.sv
// Shared constants and types for the cache BRAM port arbiter.
// Imported by the interface, the clear sequencer and the arbiter top.
package bram_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2**ADDR_W;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    LOCKED
  } arb_state_e;

  typedef enum logic {
    REQ_M0,
    REQ_M1
  } req_id_e;

endpackage

// File: rtl/bram_port_arb_if.sv
// One requester port of the BRAM arbiter: request beat plus read return.
// master = requester side, slave = arbiter side.
interface bram_port_arb_if;
  import bram_arb_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/bram_clear_seq.sv
// Post-reset sweep counter that zeroes every BRAM entry once.
// Used by bram_port_arb only when BRAM_ARB_CLEAR_EN is defined.
module bram_clear_seq
  import bram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] addr,
  output logic              active,
  output logic              last,
  output logic              done
);

  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic              done_q;

  // walk the address space once, then latch done
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == TOP) done_q <= 1'b1;
    end
  end

  assign addr   = cnt_q;
  assign active = ~done_q;
  assign last   = ~done_q & (cnt_q == TOP);
  assign done   = done_q;

endmodule

// File: rtl/bram_port_arb.sv
// Shares one single-port cache BRAM between lookup (m0) and refill (m1).
// Optional post-reset zero sweep enabled by macro BRAM_ARB_CLEAR_EN.
module bram_port_arb
  import bram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  bram_port_arb_if.slave    m0,
  bram_port_arb_if.slave    m1,
  input  logic              m1_lock,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              init_done
);

  arb_state_e state_q, state_d;
  req_id_e    last_q, last_d;

  logic g0, g1;
  logic rv0_q, rv1_q;

  logic              clr_active;
  logic              clr_last;
  logic [ADDR_W-1:0] clr_addr;

`ifdef BRAM_ARB_CLEAR_EN
  localparam arb_state_e RST_STATE = CLEAR;

  logic clr_done;

  bram_clear_seq u_clr (
    .clk    (clk),
    .resetn (resetn),
    .addr   (clr_addr),
    .active (clr_active),
    .last   (clr_last),
    .done   (clr_done)
  );

  assign init_done = clr_done;
`else
  localparam arb_state_e RST_STATE = RUN;

  logic init_q;

  assign clr_active = 1'b0;
  assign clr_last   = 1'b0;
  assign clr_addr   = '0;

  // array is usable from the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) init_q <= 1'b0;
    else         init_q <= 1'b1;
  end

  assign init_done = init_q;
`endif

  // state, round-robin pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RST_STATE;
      last_q  <= REQ_M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // grant decision and next state
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    g0      = 1'b0;
    g1      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        if (clr_last) state_d = RUN;
      end
      RUN: begin
        if (init_done) begin
          if (m0.req && m1.req) begin
            if (last_q == REQ_M1) g0 = 1'b1;
            else                  g1 = 1'b1;
          end else begin
            g0 = m0.req;
            g1 = m1.req;
          end
        end
      end
      LOCKED: begin
        g1 = m1.req;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (g0) last_d = REQ_M0;
    if (g1) begin
      last_d  = REQ_M1;
      state_d = m1_lock ? LOCKED : RUN;
    end
  end

  // steer the active source onto the BRAM pins
  always_comb begin
    bram_en    = g0 | g1 | clr_active;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    unique case (1'b1)
      clr_active: begin
        bram_we   = 1'b1;
        bram_addr = clr_addr;
      end
      g1: begin
        bram_we    = m1.we;
        bram_addr  = m1.addr;
        bram_wdata = m1.wdata;
      end
      g0: begin
        bram_we    = m0.we;
        bram_addr  = m0.addr;
        bram_wdata = m0.wdata;
      end
      default: ;
    endcase
  end

  // read return strobes, one cycle after a granted read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= g0 & ~m0.we;
      rv1_q <= g1 & ~m1.we;
    end
  end

  assign m0.gnt    = g0;
  assign m1.gnt    = g1;
  assign m0.rvalid = rv0_q;
  assign m1.rvalid = rv1_q;
  assign m0.rdata  = bram_rdata;
  assign m1.rdata  = bram_rdata;

endmodule
